// File: rtl/seg7_reader_if.sv
// Output channel of seg7_reader: decoded digit pair, error flags and a
// single-entry valid/ready handshake with a sticky overrun flag.
interface seg7_reader_if;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       err1;
  logic       err0;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  modport master (
    output dig1, dig0, err1, err0, out_valid, overrun,
    input  out_ready
  );

  modport slave (
    input  dig1, dig0, err1, err0, out_valid, overrun,
    output out_ready
  );
endinterface

// File: rtl/seg7_reader.sv
// Recovers a two-digit BCD value from active-low HEX1/HEX0 segment drives,
// debounced over STABLE_CYCLES samples and presented through a one-entry register.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [6:0]           HEX1_in,
  input  logic [6:0]           HEX0_in,
  input  logic                 ovr_clr,
  seg7_reader_if.master        out_if
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned PAIR_W = 2 * SEG_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DIG_W  = 4;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PAIR_W-1:0] PAIR_BLNK = {7'h7F, 7'h7F};

  // Inverse of the digit-to-segment table; returns {err, digit}.
  function automatic logic [DIG_W:0] seg_decode(input logic [SEG_W-1:0] seg);
    logic [DIG_W:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h10:   res = 5'h09;
      default: res = 5'h1F;
    endcase
    return res;
  endfunction

  logic [PAIR_W-1:0] r_in_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_have_last;
  logic [PAIR_W-1:0] r_last_pair;
  logic [DIG_W-1:0]  r_dig1;
  logic [DIG_W-1:0]  r_dig0;
  logic              r_err1;
  logic              r_err0;
  logic              r_out_valid;
  logic              r_overrun;

  logic [PAIR_W-1:0] w_pair;
  logic              w_same;
  logic              w_fire;
  logic              w_emit;
  logic              w_xfer;
  logic [DIG_W:0]    w_dec1;
  logic [DIG_W:0]    w_dec0;

  assign w_pair = {HEX1_in, HEX0_in};
  assign w_same = (w_pair == r_in_q);
  assign w_fire = w_same && (r_cnt == CNT_LAST);
  // Suppress repeats of the pair already delivered; a reset forgets it.
  assign w_emit = w_fire && (!r_have_last || (w_pair != r_last_pair));
  assign w_xfer = r_out_valid && out_if.out_ready;
  assign w_dec1 = seg_decode(HEX1_in);
  assign w_dec0 = seg_decode(HEX0_in);

  // Input sampler and saturating stability counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_in_q <= PAIR_BLNK;
      r_cnt  <= '0;
    end else begin
      r_in_q <= w_pair;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Last emitted pair, used for repeat suppression.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_have_last <= 1'b0;
      r_last_pair <= PAIR_BLNK;
    end else if (w_emit) begin
      r_have_last <= 1'b1;
      r_last_pair <= w_pair;
    end
  end

  // Single-entry output register; a new capture always replaces the old one.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_dig1      <= '0;
      r_dig0      <= '0;
      r_err1      <= 1'b0;
      r_err0      <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_emit) begin
        r_dig1      <= w_dec1[DIG_W-1:0];
        r_dig0      <= w_dec0[DIG_W-1:0];
        r_err1      <= w_dec1[DIG_W];
        r_err0      <= w_dec0[DIG_W];
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      // Overwrite of an unconsumed capture takes priority over the clear.
      if (w_emit && r_out_valid && !out_if.out_ready) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_if.dig1      = r_dig1;
  assign out_if.dig0      = r_dig0;
  assign out_if.err1      = r_err1;
  assign out_if.err0      = r_err0;
  assign out_if.out_valid = r_out_valid;
  assign out_if.overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: scoreboard of expected captures checked on
// each transfer, plus direct checks of handshake, overrun and reset behaviour.
module tb_seg7_reader;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [6:0] hex1 = 7'h24;
  logic [6:0] hex0 = 7'h12;
  logic       ovr_clr = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [9:0]  sb[$];

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .HEX1_in (hex1),
    .HEX0_in (hex0),
    .ovr_clr (ovr_clr),
    .out_if  (bus.master)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] word(input logic [3:0] d1, input logic [3:0] d0,
                                      input logic e1, input logic e0);
    return {d1, d0, e1, e0};
  endfunction

  function automatic logic [9:0] obs_word();
    return {bus.dig1, bus.dig0, bus.err1, bus.err0};
  endfunction

  // Advance n rising edges, landing 2 time units after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic drive(input logic [6:0] h1, input logic [6:0] h0);
    hex1 = h1;
    hex0 = h0;
  endtask

  // Scoreboard: every transfer must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Resetn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_emit", 32'(obs_word()), 32'h3FF_FFFF);
      else chk("xfer_data", 32'(obs_word()), 32'(sb.pop_front()));
    end
  end

  initial begin
    bus.out_ready = 1'b1;

    // Reset state, inputs already presenting 24/12.
    step(2);
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun),   32'd0);
    chk("rst_data",    32'(obs_word()),    32'(word(4'd0, 4'd0, 1'b0, 1'b0)));
    Resetn = 1'b1;

    // 24/12 held: emit 2/5 exactly five edges after the change, one cycle wide.
    sb.push_back(word(4'd2, 4'd5, 1'b0, 1'b0));
    step(4);
    chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("lat_valid",  32'(bus.out_valid), 32'd1);
    chk("lat_data",   32'(obs_word()),    32'(word(4'd2, 4'd5, 1'b0, 1'b0)));
    step(1);
    chk("pulse_end",  32'(bus.out_valid), 32'd0);
    step(6);
    chk("hold_no_reemit", 32'(bus.out_valid), 32'd0);

    // Short glitch to 30/10 and back: nothing emitted.
    drive(7'h30, 7'h10);
    step(3);
    drive(7'h24, 7'h12);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("glitch_quiet", 32'(bus.out_valid), 32'd0);
    end

    // 30/10 held: single emit of 3/9.
    drive(7'h30, 7'h10);
    sb.push_back(word(4'd3, 4'd9, 1'b0, 1'b0));
    step(5);
    chk("d39_valid", 32'(bus.out_valid), 32'd1);
    chk("d39_data",  32'(obs_word()),    32'(word(4'd3, 4'd9, 1'b0, 1'b0)));
    step(6);
    chk("d39_single", 32'(bus.out_valid), 32'd0);

    // Blank tens digit: F with err1.
    drive(7'h7F, 7'h79);
    sb.push_back(word(4'hF, 4'd1, 1'b1, 1'b0));
    step(5);
    chk("illegal_valid", 32'(bus.out_valid), 32'd1);
    chk("illegal_data",  32'(obs_word()),    32'(word(4'hF, 4'd1, 1'b1, 1'b0)));
    step(2);

    // Consumer stalled: 40/40 then 79/79 overwrites and flags overrun.
    bus.out_ready = 1'b0;
    drive(7'h40, 7'h40);
    step(5);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_data",  32'(obs_word()),    32'(word(4'd0, 4'd0, 1'b0, 1'b0)));
    chk("stall_no_ovr", 32'(bus.overrun),  32'd0);
    drive(7'h79, 7'h79);
    sb.push_back(word(4'd1, 4'd1, 1'b0, 1'b0));
    step(5);
    chk("ovr_valid", 32'(bus.out_valid), 32'd1);
    chk("ovr_data",  32'(obs_word()),    32'(word(4'd1, 4'd1, 1'b0, 1'b0)));
    chk("ovr_set",   32'(bus.overrun),   32'd1);
    step(3);
    chk("ovr_sticky", 32'(bus.overrun),  32'd1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared",     32'(bus.overrun),   32'd0);
    chk("ovr_valid_holds", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step(1);
    chk("ready_drops_valid", 32'(bus.out_valid), 32'd0);

    // Emit on the same edge as a transfer: new data, valid stays, no overrun.
    bus.out_ready = 1'b0;
    drive(7'h24, 7'h12);
    sb.push_back(word(4'd2, 4'd5, 1'b0, 1'b0));
    step(5);
    chk("co_first_valid", 32'(bus.out_valid), 32'd1);
    drive(7'h30, 7'h10);
    sb.push_back(word(4'd3, 4'd9, 1'b0, 1'b0));
    step(4);
    bus.out_ready = 1'b1;
    step(1);
    chk("co_valid",   32'(bus.out_valid), 32'd1);
    chk("co_data",    32'(obs_word()),    32'(word(4'd3, 4'd9, 1'b0, 1'b0)));
    chk("co_no_ovr",  32'(bus.overrun),   32'd0);
    step(1);
    chk("co_drained", 32'(bus.out_valid), 32'd0);

    // Reset with a pending capture and a count in progress.
    bus.out_ready = 1'b0;
    drive(7'h40, 7'h40);
    step(5);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    drive(7'h12, 7'h12);
    step(3);
    Resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_data",  32'(obs_word()),    32'(word(4'd0, 4'd0, 1'b0, 1'b0)));
    chk("async_rst_ovr",   32'(bus.overrun),   32'd0);
    drive(7'h40, 7'h40);
    bus.out_ready = 1'b1;
    step(2);
    Resetn = 1'b1;
    sb.push_back(word(4'd0, 4'd0, 1'b0, 1'b0));
    step(4);
    chk("post_rst_early", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("post_rst_reemit", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data",   32'(obs_word()),    32'(word(4'd0, 4'd0, 1'b0, 1'b0)));
    step(4);
    chk("post_rst_quiet",  32'(bus.out_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
